// File: rtl/operand_fetch.sv
// Operand fetch stage: latches a decoded instruction, stalls on RAW hazards
// against a pending-write scoreboard, reads the register file and holds the bundle.
module operand_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        inValid,
  output logic        inReady,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic        writesRd,
  output logic [4:0]  readRegister1,
  output logic [4:0]  readRegister2,
  input  logic [31:0] readData1,
  input  logic [31:0] readData2,
  input  logic        wbValid,
  input  logic [4:0]  wbAddr,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] opA,
  output logic [31:0] opB,
  output logic [4:0]  outRd,
  output logic        outWritesRd
);

  typedef enum logic [1:0] {IDLE, CHECK, READ, HOLD} stateT;

  stateT       state;
  stateT       nextState;
  logic [4:0]  rsQ;
  logic [4:0]  rtQ;
  logic [4:0]  rdQ;
  logic        writesRdQ;
  logic [31:0] pending;
  logic [31:0] setMask;
  logic [31:0] clrMask;
  logic        hazard;

  assign readRegister1 = rsQ;
  assign readRegister2 = rtQ;

  // Hazard uses the registered scoreboard, so a writeback landing this cycle still stalls.
  assign hazard = (pending[rsQ] && (rsQ != 5'd0)) || (pending[rtQ] && (rtQ != 5'd0));

  always_comb begin
    nextState = state;
    inReady   = 1'b0;
    outValid  = 1'b0;
    case (state)
      IDLE: begin
        inReady = 1'b1;
        if (inValid) nextState = CHECK;
      end
      CHECK: begin
        if (!hazard) nextState = READ;
      end
      READ: begin
        nextState = HOLD;
      end
      HOLD: begin
        outValid = 1'b1;
        if (outReady) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsQ       <= 5'd0;
      rtQ       <= 5'd0;
      rdQ       <= 5'd0;
      writesRdQ <= 1'b0;
    end else if (state == IDLE && inValid) begin
      rsQ       <= rs;
      rtQ       <= rt;
      rdQ       <= rd;
      writesRdQ <= writesRd;
    end
  end

  // Register 0 always reads as zero regardless of what the register file returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opA         <= 32'd0;
      opB         <= 32'd0;
      outRd       <= 5'd0;
      outWritesRd <= 1'b0;
    end else if (state == READ) begin
      opA         <= (rsQ == 5'd0) ? 32'd0 : readData1;
      opB         <= (rtQ == 5'd0) ? 32'd0 : readData2;
      outRd       <= rdQ;
      outWritesRd <= writesRdQ;
    end
  end

  // The destination is marked after its own operands are read, and a set beats a same-edge clear.
  assign setMask = (state == READ && writesRdQ && rdQ != 5'd0) ? (32'd1 << rdQ) : 32'd0;
  assign clrMask = (wbValid && wbAddr != 5'd0) ? (32'd1 << wbAddr) : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= 32'd0;
    else       pending <= ((pending & ~clrMask) | setMask) & ~32'd1;
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed instructions push expected bundles,
// a monitor compares every presented bundle against the queue head.
module tb_operand_fetch;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  d;
    logic        w;
  } bundleT;

  logic        clk;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        writesRd;
  logic [4:0]  readRegister1;
  logic [4:0]  readRegister2;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic        wbValid;
  logic [4:0]  wbAddr;
  logic [31:0] wbData;
  logic        outValid;
  logic        outReady;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [4:0]  outRd;
  logic        outWritesRd;

  logic [31:0] regs [32];
  bit          regsLoaded = 1'b0;
  bundleT      sb [$];
  int          checks = 0;
  int          failures = 0;

  operand_fetch dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .rs(rs), .rt(rt), .rd(rd), .writesRd(writesRd),
    .readRegister1(readRegister1), .readRegister2(readRegister2),
    .readData1(readData1), .readData2(readData2),
    .wbValid(wbValid), .wbAddr(wbAddr),
    .outValid(outValid), .outReady(outReady),
    .opA(opA), .opB(opB), .outRd(outRd), .outWritesRd(outWritesRd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read register file model; r0 deliberately returns garbage.
  always @(posedge clk) begin
    if (!regsLoaded) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      regs[0] <= 32'h0000DEAD;
      regs[1] <= 32'h00001111;
      regs[2] <= 32'h00002222;
      regs[3] <= 32'h00000011;
      regs[4] <= 32'h00000022;
      regsLoaded <= 1'b1;
    end else if (wbValid && wbAddr != 5'd0) begin
      regs[wbAddr] <= wbData;
    end
    readData1 <= regs[readRegister1];
    readData2 <= regs[readRegister2];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every cycle a bundle is presented it must match the head; pop on handshake.
  always @(negedge clk) begin
    if (!reset && outValid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpectedOutValid", 32'd1, 32'd0);
      end else begin
        checkOutput("opA", opA, sb[0].a);
        checkOutput("opB", opB, sb[0].b);
        checkOutput("outRd", {27'd0, outRd}, {27'd0, sb[0].d});
        checkOutput("outWritesRd", {31'd0, outWritesRd}, {31'd0, sb[0].w});
        if (outReady) void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d, input logic w);
    int n = 0;
    while (!inReady && n < 50) begin
      tick();
      n++;
    end
    if (!inReady) checkOutput("inReadyTimeout", {31'd0, inReady}, 32'd1);
    rs = a;
    rt = b;
    rd = d;
    writesRd = w;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
  endtask

  task automatic pushExp(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d, input logic w);
    bundleT e;
    e.a = a;
    e.b = b;
    e.d = d;
    e.w = w;
    sb.push_back(e);
  endtask

  task automatic waitDrain(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    checkOutput("drainTimeout", sb.size(), 32'd0);
  endtask

  task automatic stallCheck(input int cycles);
    repeat (cycles) begin
      checkOutput("stallOutValid", {31'd0, outValid}, 32'd0);
      checkOutput("stallInReady", {31'd0, inReady}, 32'd0);
      tick();
    end
  endtask

  task automatic wbPulse(input logic [4:0] addr, input logic [31:0] data);
    wbValid = 1'b1;
    wbAddr = addr;
    wbData = data;
    tick();
    wbValid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    inValid = 1'b0;
    rs = 5'd0;
    rt = 5'd0;
    rd = 5'd0;
    writesRd = 1'b0;
    wbValid = 1'b0;
    wbAddr = 5'd0;
    wbData = 32'd0;
    outReady = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rstInReady", {31'd0, inReady}, 32'd1);
    checkOutput("rstOutValid", {31'd0, outValid}, 32'd0);
    checkOutput("rstReadReg1", {27'd0, readRegister1}, 32'd0);
    checkOutput("rstReadReg2", {27'd0, readRegister2}, 32'd0);
    checkOutput("rstOpA", opA, 32'd0);
    tick();

    $display("[TB] basic fetch and latency");
    pushExp(32'h11, 32'h22, 5'd5, 1'b1);
    applyStimulus(5'd3, 5'd4, 5'd5, 1'b1);
    checkOutput("latE0", {31'd0, outValid}, 32'd0);
    checkOutput("readReg1", {27'd0, readRegister1}, 32'd3);
    tick();
    checkOutput("latE1", {31'd0, outValid}, 32'd0);
    tick();
    checkOutput("latE2", {31'd0, outValid}, 32'd1);
    waitDrain(10);

    $display("[TB] stall on pending r5 until writeback");
    pushExp(32'h55, 32'h0, 5'd6, 1'b0);
    applyStimulus(5'd5, 5'd0, 5'd6, 1'b0);
    stallCheck(6);
    wbPulse(5'd5, 32'h55);
    waitDrain(20);

    $display("[TB] r0 operands and rd=0");
    pushExp(32'h0, 32'h0, 5'd0, 1'b1);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b1);
    waitDrain(10);
    wbPulse(5'd9, 32'h99);

    $display("[TB] backpressure in HOLD");
    outReady = 1'b0;
    pushExp(32'h1111, 32'h2222, 5'd0, 1'b0);
    applyStimulus(5'd1, 5'd2, 5'd0, 1'b0);
    repeat (2) tick();
    repeat (5) begin
      checkOutput("holdOutValid", {31'd0, outValid}, 32'd1);
      checkOutput("holdInReady", {31'd0, inReady}, 32'd0);
      tick();
    end
    outReady = 1'b1;
    tick();
    checkOutput("releaseOutValid", {31'd0, outValid}, 32'd0);
    checkOutput("releaseInReady", {31'd0, inReady}, 32'd1);
    checkOutput("releaseDrained", sb.size(), 32'd0);

    $display("[TB] set wins over same-edge clear");
    pushExp(32'h0, 32'h0, 5'd7, 1'b1);
    applyStimulus(5'd0, 5'd0, 5'd7, 1'b1);
    waitDrain(10);
    pushExp(32'h0, 32'h0, 5'd7, 1'b1);
    applyStimulus(5'd0, 5'd0, 5'd7, 1'b1);
    tick();
    wbPulse(5'd7, 32'h70);
    waitDrain(10);
    pushExp(32'h77, 32'h0, 5'd8, 1'b0);
    applyStimulus(5'd7, 5'd0, 5'd8, 1'b0);
    stallCheck(6);
    wbPulse(5'd7, 32'h77);
    waitDrain(20);

    $display("[TB] rd equal to sources does not self-stall");
    pushExp(32'h55, 32'h55, 5'd5, 1'b1);
    applyStimulus(5'd5, 5'd5, 5'd5, 1'b1);
    waitDrain(10);

    $display("[TB] reset during stall");
    applyStimulus(5'd5, 5'd0, 5'd1, 1'b0);
    stallCheck(3);
    reset = 1'b1;
    #2;
    checkOutput("midRstOutValid", {31'd0, outValid}, 32'd0);
    checkOutput("midRstReadReg1", {27'd0, readRegister1}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("postRstInReady", {31'd0, inReady}, 32'd1);
    checkOutput("postRstOutValid", {31'd0, outValid}, 32'd0);
    tick();
    pushExp(32'h55, 32'h11, 5'd2, 1'b0);
    applyStimulus(5'd5, 5'd3, 5'd2, 1'b0);
    waitDrain(6);

    repeat (3) tick();
    checkOutput("finalQueueEmpty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have: inValid  in  1  decoded instruction offered.
REQ-004 SHALL have: inReady  out  1  instruction accepted when inValid && inReady at rising edge.
REQ-005 SHALL have: rs, rt, rd  in  5 each  source A, source B, destination register numbers.
REQ-006 SHALL have: writesRd  in  1  instruction will write rd.
REQ-007 SHALL have: readRegister1, readRegister2  out  5 each  register-file read addresses.
REQ-008 SHALL have: readData1, readData2  in  32 each  register-file data, valid one clock after address sampled.
REQ-009 SHALL have: wbValid  in  1, wbAddr  in  5  writeback completion notice (same cycle the register file is written).
REQ-010 SHALL have: outValid  out  1, outReady  in  1  operand-bundle handshake.
REQ-011 SHALL have: opA, opB  out  32 each; outRd  out  5; outWritesRd  out  1.

Function
REQ-012 SHALL implement FSM states IDLE, CHECK, READ, HOLD.
REQ-013 IDLE: inReady=1; on accept latch rs, rt, rd, writesRd; go CHECK. All other states: inReady=0.
REQ-014 readRegister1/2 SHALL drive latched rs/rt continuously in every state.
REQ-015 SHALL keep a 32-bit pending scoreboard; bit 0 permanently 0.
REQ-016 hazard = (pending[rs] && rs!=0) || (pending[rt] && rt!=0), evaluated on latched values using the registered scoreboard (a bit cleared this cycle still counts as hazard).
REQ-017 CHECK: hazard -> stay CHECK; no hazard -> READ.
REQ-018 READ: capture opA = (rs==0) ? 0 : readData1, opB likewise from readData2; capture outRd, outWritesRd; go HOLD.
REQ-019 HOLD: outValid=1; outputs stable; on outReady -> IDLE with outValid=0 next cycle.
REQ-020 Hazard-free latency: accept edge E0, CHECK during E0-E1, READ during E1-E2, outValid=1 from E2.
REQ-021 On the READ->HOLD edge, if writesRd && rd!=0, SHALL set pending[rd].
REQ-022 wbValid && wbAddr!=0 SHALL clear pending[wbAddr] on that edge; wbAddr=0 ignored.
REQ-023 Set and clear of same bit on same edge: set wins.
REQ-024 rd equal to rs or rt of the same instruction SHALL NOT self-stall (set occurs after read).
REQ-025 wbValid for a non-pending register SHALL leave the scoreboard unchanged.
REQ-026 Stall in CHECK is unbounded; no timeout.

Reset
REQ-027 On reset assertion, asynchronously: state=IDLE, pending=0, outValid=0, opA=opB=0, outRd=0, outWritesRd=0, latched rs/rt/rd=0 (so readRegister1/2=0).
REQ-028 inReady SHALL read 1 from the first cycle after reset deasserts.
REQ-029 Reset mid-operation (CHECK, READ or HOLD) SHALL discard the instruction and all pending bits; no outValid pulse.

Verification
REQ-030 Reset, then rs=3, rt=4, rd=5, writesRd=1, regfile r3=0x11, r4=0x22 -> outValid at E2, opA=0x11, opB=0x22, outRd=5, pending[5]=1.
REQ-031 With pending[5]=1, issue rs=5 -> stays CHECK; wbValid, wbAddr=5 at cycle N (r5=0x55 written) -> READ at N+1, opA=0x55.
REQ-032 rs=0, rt=0, regfile r0 returns 0xDEAD -> opA=opB=0; writesRd=1, rd=0 -> pending stays 0.
REQ-033 HOLD with outReady=0 for 5 cycles -> outValid, opA, opB stable, inReady=0; outReady=1 -> IDLE, inReady=1 next cycle.
REQ-034 pending[7]=1, READ->HOLD sets rd=7 on the same edge wbAddr=7 -> pending[7]=1.
REQ-035 Assert reset during CHECK stall -> outValid=0, pending=0, inReady=1 after release.
